sub_serial: RTL and testbench

Bit-serial ripple-borrow subtractor computing diff = a − b − bin over WIDTH bits, one bit per clock, LSB first. It is the inverse-direction companion to the combinational carry-propagate adder `add_cp_4`: one full-subtractor cell plus a borrow flip-flop instead of WIDTH parallel cells. A start/busy/done handshake lets a controller or testbench launch an operation and collect a registered result. The result stays stable between operations.

---
 rtl/sub_serial.sv | 117 +++++++++++
 tb/tb_sub_serial.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sub_serial.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Optional signed-overflow output is enabled by defining SUB_SERIAL_OVF_EN.
module sub_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] part;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             br_nxt;
`ifdef SUB_SERIAL_OVF_EN
    // Operand sign bits are shifted out of sa/sb, so keep copies for the overflow test.
    logic             a_msb;
    logic             b_msb;
`endif

    // Single full-subtractor cell operating on the current LSBs.
    always_comb begin
        d      = sa[0] ^ sb[0] ^ br;
        br_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            sa    <= '0;
            sb    <= '0;
            part  <= '0;
            br    <= 1'b0;
            cnt   <= '0;
`ifdef SUB_SERIAL_OVF_EN
            ovf   <= 1'b0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= SHIFT;
                        busy  <= 1'b1;
                        sa    <= a;
                        sb    <= b;
                        br    <= bin;
                        cnt   <= '0;
`ifdef SUB_SERIAL_OVF_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    part <= {d, part[WIDTH-1:1]};
                    sa   <= sa >> 1;
                    sb   <= sb >> 1;
                    br   <= br_nxt;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        diff  <= {d, part[WIDTH-1:1]};
                        bout  <= br_nxt;
`ifdef SUB_SERIAL_OVF_EN
                        // The last processed bit d is the result's sign bit.
                        ovf   <= (a_msb != b_msb) & (d != a_msb);
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_serial.sv
// Directed self-checking bench for sub_serial (WIDTH=4), immediate-assertion style.
module tb_sub_serial;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SUB_SERIAL_OVF_EN
    logic             ovf;
`endif

    int checks = 0;
    int errors = 0;

    sub_serial #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SUB_SERIAL_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation and check latency, busy width and the result.
    task automatic run_op(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                          input logic tbin, input logic [3:0] ediff, input logic ebout,
                          input logic eovf);
        int cycles;
        int busy_cnt;
        a     = ta;
        b     = tb;
        bin   = tbin;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = ~ta;
        b     = ~tb;
        bin   = ~tbin;
        cycles   = 0;
        busy_cnt = 0;
        while (!done && cycles < 20) begin
            if (busy) busy_cnt++;
            tick();
            cycles++;
        end
        check({tag, "_latency"}, cycles, WIDTH);
        check({tag, "_busy_cycles"}, busy_cnt, WIDTH);
        check({tag, "_busy_at_done"}, busy, 1'b0);
        check({tag, "_diff"}, diff, ediff);
        check({tag, "_bout"}, bout, ebout);
`ifdef SUB_SERIAL_OVF_EN
        check({tag, "_ovf"}, ovf, eovf);
`else
        if (eovf === 1'bx) $display("unexpected x in expected ovf");
`endif
        tick();
        check({tag, "_done_drop"}, done, 1'b0);
    endtask

    initial begin
        int pulses;
        int first_done;
        int second_done;
        logic stable;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        #12;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_diff", diff, 4'b0000);
        check("reset_bout", bout, 1'b0);
`ifdef SUB_SERIAL_OVF_EN
        check("reset_ovf", ovf, 1'b0);
`endif
        rst_n = 1'b1;
        tick();

        run_op("v1", 4'b1000, 4'b0011, 1'b0, 4'b0101, 1'b0, 1'b1);
        run_op("v2", 4'b0000, 4'b0011, 1'b0, 4'b1101, 1'b1, 1'b0);
        run_op("v3", 4'b1000, 4'b1011, 1'b0, 4'b1101, 1'b1, 1'b0);
        run_op("v4", 4'b0101, 4'b0101, 1'b1, 4'b1111, 1'b1, 1'b0);

        // start re-pulsed mid-SHIFT with other operands must be ignored: 9-2 = 7.
        a = 4'd9; b = 4'd2; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        pulses = 0;
        tick();
        a = 4'd1; b = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done) pulses++;
            tick();
        end
        check("repulse_done_count", pulses, 1);
        check("repulse_diff", diff, 4'd7);
        check("repulse_bout", bout, 1'b0);
`ifdef SUB_SERIAL_OVF_EN
        check("repulse_ovf", ovf, 1'b1);
`endif

        // start held high: one operation every WIDTH+2 cycles, 6-1 = 5.
        a = 4'd6; b = 4'd1; bin = 1'b0; start = 1'b1;
        pulses = 0; first_done = -1; second_done = -1;
        for (int i = 1; i <= 18; i++) begin
            tick();
            if (done) begin
                pulses++;
                if (first_done < 0) first_done = i;
                else if (second_done < 0) second_done = i;
            end
        end
        start = 1'b0;
        check("held_done_count", pulses, 3);
        check("held_period", second_done - first_done, WIDTH + 2);
        check("held_diff", diff, 4'd5);
        tick();
        check("held_idle_busy", busy, 1'b0);

        // Reset after bit 2 of 12-1: outputs clear at once, no done afterwards.
        a = 4'd12; b = 4'd1; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_diff", diff, 4'b0000);
        check("abort_bout", bout, 1'b0);
`ifdef SUB_SERIAL_OVF_EN
        check("abort_ovf", ovf, 1'b0);
`endif
        tick();
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done || busy) pulses++;
        end
        check("abort_no_activity", pulses, 0);
        run_op("fresh", 4'd12, 4'd1, 1'b0, 4'b1011, 1'b0, 1'b0);

        // Operands wander while IDLE; the result must hold.
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a   = 4'($urandom_range(0, 15));
            b   = 4'($urandom_range(0, 15));
            bin = 1'($urandom_range(0, 1));
            tick();
            if (diff !== 4'b1011 || bout !== 1'b0 || done !== 1'b0) stable = 1'b0;
        end
        check("idle_hold_stable", stable, 1'b1);
        check("idle_hold_diff", diff, 4'b1011);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
